// File: rtl/hood_mode_fsm_if.sv
// rtl/hood_mode_fsm_if.sv - key inputs and mode broadcast outputs of the hood mode FSM
interface hood_mode_fsm_if #(
    parameter int MODE_WIDTH  = 3,
    parameter int TIMER_WIDTH = 33
);
    logic                   power_key;
    logic                   menu_key;
    logic                   level1_key;
    logic                   level2_key;
    logic                   level3_key;
    logic                   clean_key;
    logic                   from_clean_toggle;
    logic [MODE_WIDTH-1:0]  current_mode;
    logic                   level3_used;
    logic                   mode_changed;
    logic [TIMER_WIDTH-1:0] l3_remaining;

    modport master (
        output power_key, menu_key, level1_key, level2_key, level3_key, clean_key,
               from_clean_toggle,
        input  current_mode, level3_used, mode_changed, l3_remaining
    );

    modport slave (
        input  power_key, menu_key, level1_key, level2_key, level3_key, clean_key,
               from_clean_toggle,
        output current_mode, level3_used, mode_changed, l3_remaining
    );
endinterface

// File: rtl/hood_mode_fsm.sv
// rtl/hood_mode_fsm.sv - range hood operating-mode FSM with timed extract-3 boost
module hood_mode_fsm #(
    parameter int                     MODE_WIDTH  = 3,
    parameter int                     TIMER_WIDTH = 33,
    parameter logic [TIMER_WIDTH-1:0] L3_CYCLES   = TIMER_WIDTH'(64'd6_000_000_000)
) (
    input  logic          clk,
    input  logic          rst,
    hood_mode_fsm_if.slave bus
);
    localparam logic [MODE_WIDTH-1:0] M_OFF   = MODE_WIDTH'(0);
    localparam logic [MODE_WIDTH-1:0] M_STAND = MODE_WIDTH'(1);
    localparam logic [MODE_WIDTH-1:0] M_MENU  = MODE_WIDTH'(2);
    localparam logic [MODE_WIDTH-1:0] M_EXT1  = MODE_WIDTH'(3);
    localparam logic [MODE_WIDTH-1:0] M_EXT2  = MODE_WIDTH'(4);
    localparam logic [MODE_WIDTH-1:0] M_EXT3  = MODE_WIDTH'(5);
    localparam logic [MODE_WIDTH-1:0] M_CLEAN = MODE_WIDTH'(6);

    logic [MODE_WIDTH-1:0]  mode_q, mode_d;
    logic                   used_q, used_d;
    logic                   changed_q;
    logic [TIMER_WIDTH-1:0] rem_q, rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= M_OFF;
            used_q    <= 1'b0;
            changed_q <= 1'b0;
            rem_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            used_q    <= used_d;
            changed_q <= (mode_d != mode_q);
            rem_q     <= rem_d;
        end
    end

    // Each branch picks at most one target; the if-chain order is the key priority.
    always_comb begin
        mode_d = mode_q;
        if (mode_q > M_CLEAN) begin
            mode_d = M_OFF;
        end else if (bus.power_key) begin
            mode_d = (mode_q == M_OFF) ? M_STAND : M_OFF;
        end else begin
            case (mode_q)
                M_STAND: if (bus.menu_key) mode_d = M_MENU;
                M_MENU: begin
                    if (bus.menu_key)                     mode_d = M_STAND;
                    else if (bus.level1_key)              mode_d = M_EXT1;
                    else if (bus.level2_key)              mode_d = M_EXT2;
                    else if (bus.level3_key && !used_q)   mode_d = M_EXT3;
                    else if (bus.clean_key)               mode_d = M_CLEAN;
                end
                M_EXT1, M_EXT2: begin
                    if (bus.menu_key)        mode_d = M_STAND;
                    else if (bus.level1_key) mode_d = M_EXT1;
                    else if (bus.level2_key) mode_d = M_EXT2;
                end
                M_EXT3:  if (rem_q == '0) mode_d = M_STAND;
                M_CLEAN: if (bus.from_clean_toggle) mode_d = M_STAND;
                default: mode_d = mode_q;
            endcase
        end

        used_d = used_q;
        if (mode_d == M_OFF)
            used_d = 1'b0;
        else if (mode_d == M_EXT3)
            used_d = 1'b1;

        rem_d = '0;
        if (mode_d == M_EXT3) begin
            if (mode_q != M_EXT3)
                rem_d = L3_CYCLES - TIMER_WIDTH'(1);
            else if (rem_q != '0)
                rem_d = rem_q - TIMER_WIDTH'(1);
        end
    end

    always_comb begin
        bus.current_mode = mode_q;
        bus.level3_used  = used_q;
        bus.mode_changed = changed_q;
        bus.l3_remaining = rem_q;
    end
endmodule

// File: tb/tb_hood_mode_fsm.sv
// tb/tb_hood_mode_fsm.sv - directed vector and sequence checks for hood_mode_fsm
module tb_hood_mode_fsm;
    localparam int MW = 3;
    localparam int TW = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    hood_mode_fsm_if #(.MODE_WIDTH(MW), .TIMER_WIDTH(TW)) bus ();

    hood_mode_fsm #(.MODE_WIDTH(MW), .TIMER_WIDTH(TW), .L3_CYCLES(TW'(10))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, pw, mn, l1, l2, l3, cl, tg;
        logic [2:0] mode;
        logic       ch, used;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, pw, mn, l1, l2, l3, cl, tg,
                                input logic [2:0] mode, input logic ch, used);
        vec_t v;
        v.r = r; v.pw = pw; v.mn = mn; v.l1 = l1; v.l2 = l2; v.l3 = l3; v.cl = cl; v.tg = tg;
        v.mode = mode; v.ch = ch; v.used = used;
        return v;
    endfunction

    task automatic drive(input logic r, pw, mn, l1, l2, l3, cl, tg);
        rst                   = r;
        bus.power_key         = pw;
        bus.menu_key          = mn;
        bus.level1_key        = l1;
        bus.level2_key        = l2;
        bus.level3_key        = l3;
        bus.clean_key         = cl;
        bus.from_clean_toggle = tg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [2:0] mode, input logic ch,
                             input logic used, input logic [TW-1:0] rem);
        chk({name, " mode"}, 64'(bus.current_mode), 64'(mode));
        chk({name, " changed"}, 64'(bus.mode_changed), 64'(ch));
        chk({name, " used"}, 64'(bus.level3_used), 64'(used));
        chk({name, " rem"}, 64'(bus.l3_remaining), 64'(rem));
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //          r pw mn l1 l2 l3 cl tg  mode ch used
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd3, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 3'd4, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 3'd1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 3'd1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd2, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 3'd6, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 3'd6, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 3'd6, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].pw, tbl[i].mn, tbl[i].l1, tbl[i].l2, tbl[i].l3,
                  tbl[i].cl, tbl[i].tg);
            tick();
            chk_state($sformatf("vec%0d", i), tbl[i].mode, tbl[i].ch, tbl[i].used, '0);
        end

        // Extract-3 dwell with an ignored menu press, then one-shot lockout
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        chk_state("l3 entry", 3'd5, 1, 1, TW'(9));
        for (int k = 1; k <= 9; k++) begin
            drive(0, 0, (k == 3), 0, 0, 0, 0, 0); tick();
            chk_state($sformatf("l3 count%0d", k), 3'd5, 0, 1, TW'(9 - k));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk_state("l3 expire", 3'd1, 1, 1, '0);
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        chk_state("menu again", 3'd2, 1, 1, '0);
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        chk_state("l3 lockout", 3'd2, 0, 1, '0);
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        chk_state("clean entry", 3'd6, 1, 1, '0);
        drive(0, 1, 0, 0, 0, 0, 0, 1); tick();
        chk_state("power over toggle", 3'd0, 1, 0, '0);

        // Clean dwell with toggle low, then release to stand
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 50; k++) tick();
        chk_state("clean hold", 3'd6, 0, 0, '0);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk_state("clean done", 3'd1, 1, 0, '0);
        tick();
        chk_state("toggle in stand", 3'd1, 0, 0, '0);

        // Reset aborts extract-3 mid-count
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        chk_state("l3 at five", 3'd5, 0, 1, TW'(5));
        drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk_state("rst in l3", 3'd0, 0, 0, '0);
        drive(0, 1, 0, 0, 0, 0, 0, 0); tick();
        chk_state("power after rst", 3'd1, 1, 0, '0);

        // Reset aborts clean with nothing pending afterwards
        drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk_state("rst in clean", 3'd0, 0, 0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
